// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Shared writeback-select encodings and hazard-sequencer state type.
// Rev 1.0 : initial release
// ============================================================================
package cpu_pkg;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_CACHE = 2'd1,
    WAIT_DMA   = 2'd2,
    ERR        = 2'd3
  } hz_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hz_mem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module : hz_mem_wait_fsm
// Tracks outstanding cache/DMA accesses with a timeout; raises mem_stall/err.
// Rev 1.0 : initial release
// ============================================================================
module hz_mem_wait_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_cache_i,
  input  logic req_dma_i,
  input  logic cache_ready_i,
  input  logic dma_ready_i,
  output logic mem_stall_o,
  output logic err_o
);

  localparam int c_tw = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(MEM_TIMEOUT - 1);

  hz_state_e       r_state;
  logic [c_tw-1:0] r_tcnt;
  logic            r_err;
  logic            w_cache_miss;
  logic            w_dma_miss;
  logic            w_wait_ready;
  logic            w_stall;

  assign w_cache_miss = req_cache_i & ~cache_ready_i;
  assign w_dma_miss   = req_dma_i & ~dma_ready_i;
  assign w_wait_ready = (r_state == WAIT_CACHE) ? cache_ready_i : dma_ready_i;

  // Stall is combinational so a miss freezes the pipe in the very cycle it appears.
  always_comb begin
    w_stall = 1'b1;
    case (r_state)
      RUN:        w_stall = w_cache_miss | w_dma_miss;
      WAIT_CACHE: w_stall = ~cache_ready_i;
      WAIT_DMA:   w_stall = ~dma_ready_i;
      default:    w_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_cache_miss) begin
            r_state <= WAIT_CACHE;
            r_tcnt  <= '0;
          end else if (w_dma_miss) begin
            r_state <= WAIT_DMA;
            r_tcnt  <= '0;
          end
        end
        WAIT_CACHE, WAIT_DMA: begin
          if (w_wait_ready) begin
            r_state <= RUN;
          end else if (r_tcnt == c_tlast) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ERR;
      endcase
    end
  end

  assign mem_stall_o = w_stall;
  assign err_o       = r_err;

endmodule : hz_mem_wait_fsm
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, memory wait.
// Rev 1.0 : initial release
// ============================================================================
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rsW_ex_i,
  input  logic             RegWEn_ex_i,
  input  logic [1:0]       WBSel_ex_i,
  input  logic             br_taken_ex_i,
  input  logic             req_cache_mem_i,
  input  logic             req_dma_mem_i,
  input  logic             cache_ready_i,
  input  logic             dma_ready_i,
  output logic             en_f_o,
  output logic             en_d_o,
  output logic             rst_d_o,
  output logic             en_ex_o,
  output logic             rst_ex_o,
  output logic             en_mem_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             w_mem_stall;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_cnt;

  hz_mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_cache_i   (req_cache_mem_i),
    .req_dma_i     (req_dma_mem_i),
    .cache_ready_i (cache_ready_i),
    .dma_ready_i   (dma_ready_i),
    .mem_stall_o   (w_mem_stall),
    .err_o         (err_o)
  );

  assign w_load_use = RegWEn_ex_i & (WBSel_ex_i == WB_MEM) & (rsW_ex_i != 5'd0) &
                      ((rsW_ex_i == rs1_d_i) | (rsW_ex_i == rs2_d_i));

  // A taken branch squashes the dependent instruction, so it outranks load-use.
  always_comb begin
    en_f_o   = 1'b0;
    en_d_o   = 1'b0;
    rst_d_o  = 1'b0;
    en_ex_o  = 1'b0;
    rst_ex_o = 1'b0;
    en_mem_o = 1'b0;
    if (rst_ni && !w_mem_stall) begin
      if (br_taken_ex_i) begin
        en_f_o   = 1'b1;
        en_d_o   = 1'b1;
        rst_d_o  = 1'b1;
        en_ex_o  = 1'b1;
        rst_ex_o = 1'b1;
        en_mem_o = 1'b1;
      end else if (w_load_use) begin
        en_ex_o  = 1'b1;
        rst_ex_o = 1'b1;
        en_mem_o = 1'b1;
      end else begin
        en_f_o   = 1'b1;
        en_d_o   = 1'b1;
        en_ex_o  = 1'b1;
        en_mem_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (!en_f_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule : pipe_hazard_ctrl
`default_nettype wire
